// File: rtl/step_clock_gen.sv
// -----------------------------------------------------------------------------
// step_clock_gen
//
// Generates the CPU clock (CPUCLK) for the SingleCycleCPU from the 100 MHz
// board clock. In single-step mode, each debounced press of a raw push button
// produces one clean pulse of fixed width. In auto-run mode, selected by a
// slide switch, a divider produces a periodic pulse train instead. A step
// counter and a busy flag are exported for the display path.
//
// Ports
//   CLK        in   1      board clock; all state updates on the rising edge
//   Reset      in   1      asynchronous, active-low reset
//   Button     in   1      raw, bouncy, asynchronous push button (1 = pressed)
//   AutoRun    in   1      raw slide switch (1 = auto-run, 0 = single-step)
//   CPUCLK     out  1      generated CPU clock (registered)
//   Busy       out  1      high during the high and low-recovery phases of a pulse
//   StepCount  out  CNT_W  CPUCLK rising edges since reset, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int PULSE_HIGH_CYCLES = 4,
  parameter int AUTO_DIV          = 50000000,
  parameter int CNT_W             = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Button,
  input  logic             AutoRun,
  output logic             CPUCLK,
  output logic             Busy,
  output logic [CNT_W-1:0] StepCount
);

  // The debounce counter is kept at least 16 bits wide even for small
  // debounce settings, and grows as needed for large ones.
  localparam int DCNT_W = ($clog2(DEBOUNCE_CYCLES + 1) > 16) ? $clog2(DEBOUNCE_CYCLES + 1) : 16;
  localparam int ACNT_W = ($clog2(AUTO_DIV) > 1) ? $clog2(AUTO_DIV) : 1;
  localparam int PCNT_W = (PULSE_HIGH_CYCLES > 1) ? $clog2(PULSE_HIGH_CYCLES) : 1;

  localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(DEBOUNCE_CYCLES);
  localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(AUTO_DIV - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_HIGH_CYCLES - 1);

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_WAIT_PRESS,
    DB_HELD,
    DB_WAIT_RELEASE
  } dbState_t;

  typedef enum logic [1:0] {
    PG_LOW,
    PG_HIGH,
    PG_RECOVER
  } pgState_t;

  logic r_btnMeta;
  logic r_btnSync;
  logic r_autoMeta;
  logic r_autoSync;

  dbState_t          r_dbState;
  dbState_t          w_dbStateNext;
  logic [DCNT_W-1:0] r_dcnt;
  logic [DCNT_W-1:0] w_dcntNext;
  logic              w_btnReq;

  logic [ACNT_W-1:0] r_acnt;
  logic              w_autoReq;
  logic              w_req;

  pgState_t          r_pgState;
  pgState_t          w_pgStateNext;
  logic [PCNT_W-1:0] r_pcnt;
  logic [PCNT_W-1:0] w_pcntNext;
  logic              r_cpuClk;
  logic              w_cpuClkNext;
  logic              r_busy;
  logic              w_busyNext;
  logic [CNT_W-1:0]  r_stepCount;
  logic [CNT_W-1:0]  w_stepCountNext;

  // Two-flop synchronizers for both raw inputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_btnMeta  <= 1'b0;
      r_btnSync  <= 1'b0;
      r_autoMeta <= 1'b0;
      r_autoSync <= 1'b0;
    end else begin
      r_btnMeta  <= Button;
      r_btnSync  <= r_btnMeta;
      r_autoMeta <= AutoRun;
      r_autoSync <= r_autoMeta;
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_dbState <= DB_IDLE;
      r_dcnt    <= '0;
    end else begin
      r_dbState <= w_dbStateNext;
      r_dcnt    <= w_dcntNext;
    end
  end

  // Debounce next-state logic. A level change is accepted only after it has
  // been seen stable long enough; the request fires once on the accepted
  // press, and bounces on release fall back to HELD without a new request.
  always_comb begin
    w_dbStateNext = r_dbState;
    w_dcntNext    = r_dcnt;
    w_btnReq      = 1'b0;
    case (r_dbState)
      DB_IDLE: begin
        if (r_btnSync) begin
          w_dbStateNext = DB_WAIT_PRESS;
          w_dcntNext    = DCNT_W'(1);
        end
      end
      DB_WAIT_PRESS: begin
        if (!r_btnSync) begin
          w_dbStateNext = DB_IDLE;
          w_dcntNext    = '0;
        end else if (r_dcnt == DCNT_MAX) begin
          w_dbStateNext = DB_HELD;
          w_dcntNext    = '0;
          w_btnReq      = 1'b1;
        end else begin
          w_dcntNext = r_dcnt + DCNT_W'(1);
        end
      end
      DB_HELD: begin
        if (!r_btnSync) begin
          w_dbStateNext = DB_WAIT_RELEASE;
          w_dcntNext    = DCNT_W'(1);
        end
      end
      DB_WAIT_RELEASE: begin
        if (r_btnSync) begin
          w_dbStateNext = DB_HELD;
          w_dcntNext    = '0;
        end else if (r_dcnt == DCNT_MAX) begin
          w_dbStateNext = DB_IDLE;
          w_dcntNext    = '0;
        end else begin
          w_dcntNext = r_dcnt + DCNT_W'(1);
        end
      end
      default: begin
        w_dbStateNext = DB_IDLE;
        w_dcntNext    = '0;
      end
    endcase
  end

  // Auto-run divider: parked at zero while the switch is off, so the first
  // request always comes a full period after auto-run is selected.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_acnt <= '0;
    end else if (!r_autoSync) begin
      r_acnt <= '0;
    end else if (r_acnt == ACNT_LAST) begin
      r_acnt <= '0;
    end else begin
      r_acnt <= r_acnt + ACNT_W'(1);
    end
  end

  assign w_autoReq = r_autoSync && (r_acnt == ACNT_LAST);

  // In auto-run mode button requests are discarded; the debouncer still
  // tracks the button so switching modes never leaves it in a stale state.
  assign w_req = r_autoSync ? w_autoReq : w_btnReq;

  // Pulse generator state register; CPUCLK, Busy and StepCount are all
  // registered so the CPU sees a glitch-free clock.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_pgState   <= PG_LOW;
      r_pcnt      <= '0;
      r_cpuClk    <= 1'b0;
      r_busy      <= 1'b0;
      r_stepCount <= '0;
    end else begin
      r_pgState   <= w_pgStateNext;
      r_pcnt      <= w_pcntNext;
      r_cpuClk    <= w_cpuClkNext;
      r_busy      <= w_busyNext;
      r_stepCount <= w_stepCountNext;
    end
  end

  // Pulse generator next-state logic. Requests are only honoured in LOW, so
  // anything arriving during HIGH or RECOVER is dropped rather than queued.
  always_comb begin
    w_pgStateNext   = r_pgState;
    w_pcntNext      = r_pcnt;
    w_cpuClkNext    = r_cpuClk;
    w_busyNext      = r_busy;
    w_stepCountNext = r_stepCount;
    case (r_pgState)
      PG_LOW: begin
        if (w_req) begin
          w_pgStateNext   = PG_HIGH;
          w_pcntNext      = '0;
          w_cpuClkNext    = 1'b1;
          w_busyNext      = 1'b1;
          w_stepCountNext = r_stepCount + CNT_W'(1);
        end
      end
      PG_HIGH: begin
        if (r_pcnt == PCNT_LAST) begin
          w_pgStateNext = PG_RECOVER;
          w_pcntNext    = '0;
          w_cpuClkNext  = 1'b0;
        end else begin
          w_pcntNext = r_pcnt + PCNT_W'(1);
        end
      end
      PG_RECOVER: begin
        if (r_pcnt == PCNT_LAST) begin
          w_pgStateNext = PG_LOW;
          w_pcntNext    = '0;
          w_busyNext    = 1'b0;
        end else begin
          w_pcntNext = r_pcnt + PCNT_W'(1);
        end
      end
      default: begin
        w_pgStateNext = PG_LOW;
        w_pcntNext    = '0;
        w_cpuClkNext  = 1'b0;
        w_busyNext    = 1'b0;
      end
    endcase
  end

  assign CPUCLK    = r_cpuClk;
  assign Busy      = r_busy;
  assign StepCount = r_stepCount;

endmodule

// File: tb/tb_step_clock_gen.sv
// -----------------------------------------------------------------------------
// tb_step_clock_gen
//
// Testbench for step_clock_gen with small parameters (debounce 8, pulse 2,
// auto divider 20, 4-bit step counter). Button waveforms come from a table of
// press/bounce descriptions; auto-run, wrap-around and mid-pulse reset are
// driven as hand-written sequences.
// -----------------------------------------------------------------------------
module tb_step_clock_gen;

  localparam int DEB  = 8;
  localparam int PH   = 2;
  localparam int ADIV = 20;
  localparam int CW   = 4;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Button;
  logic          AutoRun;
  logic          CPUCLK;
  logic          Busy;
  logic [CW-1:0] StepCount;

  int checks   = 0;
  int failures = 0;

  int   edgeCount    = 0;
  int   riseCount    = 0;
  int   lastRiseEdge = 0;
  int   highRun      = 0;
  int   lastHighLen  = 0;
  int   busyRun      = 0;
  int   lastBusyLen  = 0;
  logic prevCpu      = 1'b0;
  logic prevBusy     = 1'b0;

  typedef struct {
    string name;
    int    preBounces;
    int    holdCycles;
    int    postBounces;
    int    gap;
    int    expPulses;
    bit    checkTiming;
  } vec_t;

  vec_t vecs[6];

  step_clock_gen #(
    .DEBOUNCE_CYCLES  (DEB),
    .PULSE_HIGH_CYCLES(PH),
    .AUTO_DIV         (ADIV),
    .CNT_W            (CW)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Button   (Button),
    .AutoRun  (AutoRun),
    .CPUCLK   (CPUCLK),
    .Busy     (Busy),
    .StepCount(StepCount)
  );

  always #5 CLK = ~CLK;

  // Rising-edge index, used to measure latencies in clock edges.
  always @(posedge CLK) edgeCount <= edgeCount + 1;

  // Output monitor sampled on the falling edge: counts CPUCLK rising edges
  // and records the length of the latest CPUCLK-high and Busy-high runs.
  always @(negedge CLK) begin
    prevCpu  <= CPUCLK;
    prevBusy <= Busy;
    if (CPUCLK && !prevCpu) begin
      riseCount    <= riseCount + 1;
      lastRiseEdge <= edgeCount;
    end
    if (CPUCLK) highRun <= highRun + 1;
    else        highRun <= 0;
    if (!CPUCLK && prevCpu) lastHighLen <= highRun;
    if (Busy) busyRun <= busyRun + 1;
    else      busyRun <= 0;
    if (!Busy && prevBusy) lastBusyLen <= busyRun;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Drives one button waveform: optional chatter starting high, a stable
  // hold, optional release chatter starting low, then a quiet tail.
  // Returns the index of the first edge that samples Button=1.
  task automatic applyStimulus(input vec_t v, output int pressEdge);
    logic b;
    @(negedge CLK);
    pressEdge = edgeCount + 1;
    b = 1'b1;
    for (int i = 0; i < v.preBounces; i++) begin
      Button = b;
      repeat (v.gap) @(negedge CLK);
      b = ~b;
    end
    if (v.holdCycles > 0) begin
      Button = 1'b1;
      repeat (v.holdCycles) @(negedge CLK);
    end
    b = 1'b0;
    for (int i = 0; i < v.postBounces; i++) begin
      Button = b;
      repeat (v.gap) @(negedge CLK);
      b = ~b;
    end
    Button = 1'b0;
    repeat (30) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int   pressEdge;
    int   startRise;
    int   expStep;
    int   autoEdge;
    int   firstEdge;
    int   secondEdge;
    bit   got1;
    bit   got2;
    bit   found;
    vec_t pv;

    vecs[0] = '{"clean40",        0, 40, 0, 1, 1, 1'b1};
    vecs[1] = '{"chatter",       10,  0, 0, 3, 0, 1'b0};
    vecs[2] = '{"release_bounce", 0, 40, 4, 2, 1, 1'b0};
    vecs[3] = '{"press_bounce",   4, 40, 0, 2, 1, 1'b0};
    vecs[4] = '{"min_hold9",      0,  9, 0, 1, 1, 1'b0};
    vecs[5] = '{"short_hold8",    0,  8, 0, 1, 0, 1'b0};

    Reset   = 1'b1;
    Button  = 1'b0;
    AutoRun = 1'b0;

    // Asynchronous reset in the middle of a clock phase.
    repeat (3) @(negedge CLK);
    #2 Reset = 1'b0;
    #1;
    checkOutput("reset_cpuclk", CPUCLK, 0);
    checkOutput("reset_busy", Busy, 0);
    checkOutput("reset_stepcount", StepCount, 0);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    repeat (5) @(negedge CLK);

    expStep = 0;
    for (int i = 0; i < 6; i++) begin
      startRise = riseCount;
      applyStimulus(vecs[i], pressEdge);
      expStep = (expStep + vecs[i].expPulses) % 16;
      checkOutput({vecs[i].name, "_pulses"}, riseCount - startRise, vecs[i].expPulses);
      checkOutput({vecs[i].name, "_stepcount"}, StepCount, expStep);
      if (vecs[i].checkTiming) begin
        checkOutput({vecs[i].name, "_latency"}, lastRiseEdge - pressEdge + 1, DEB + 3);
        checkOutput({vecs[i].name, "_high_len"}, lastHighLen, PH);
        checkOutput({vecs[i].name, "_busy_len"}, lastBusyLen, 2 * PH);
      end
    end

    // Auto-run for 103 cycles while the button is pressed repeatedly.
    startRise  = riseCount;
    got1       = 1'b0;
    got2       = 1'b0;
    firstEdge  = 0;
    secondEdge = 0;
    @(negedge CLK);
    autoEdge = edgeCount + 1;
    AutoRun  = 1'b1;
    for (int c = 0; c < 103; c++) begin
      Button = (c < 80) && ((c % 20) < 12);
      if (!got1 && (riseCount - startRise) >= 1) begin
        got1      = 1'b1;
        firstEdge = lastRiseEdge;
      end
      if (!got2 && (riseCount - startRise) >= 2) begin
        got2       = 1'b1;
        secondEdge = lastRiseEdge;
      end
      @(negedge CLK);
    end
    AutoRun = 1'b0;
    Button  = 1'b0;
    repeat (60) @(negedge CLK);
    expStep = (expStep + 5) % 16;
    checkOutput("auto_pulses", riseCount - startRise, 5);
    checkOutput("auto_first_latency", firstEdge - autoEdge + 1, ADIV + 2);
    checkOutput("auto_period", secondEdge - firstEdge, ADIV);
    checkOutput("auto_stepcount", StepCount, expStep);

    // AutoRun dropped while the first pulse is high: that pulse completes.
    startRise = riseCount;
    AutoRun   = 1'b1;
    repeat (21) @(negedge CLK);
    AutoRun = 1'b0;
    repeat (40) @(negedge CLK);
    expStep = (expStep + 1) % 16;
    checkOutput("autodrop_pulses", riseCount - startRise, 1);
    checkOutput("autodrop_high_len", lastHighLen, PH);
    checkOutput("autodrop_busy_len", lastBusyLen, 2 * PH);
    checkOutput("autodrop_stepcount", StepCount, expStep);

    // Seventeen clean presses from reset: the counter wraps 15 -> 0 -> 1.
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    pv = '{"press", 0, 12, 0, 1, 1, 1'b0};
    for (int i = 0; i < 17; i++) begin
      applyStimulus(pv, pressEdge);
      checkOutput($sformatf("wrap_press%0d", i + 1), StepCount, (i + 1) % 16);
    end

    // Reset asserted while CPUCLK is high, button released during reset.
    @(negedge CLK);
    Button = 1'b1;
    found  = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge CLK);
      if (CPUCLK) found = 1'b1;
    end
    checkOutput("midreset_reached_high", found, 1);
    #1 Reset = 1'b0;
    #1;
    checkOutput("midreset_cpuclk", CPUCLK, 0);
    checkOutput("midreset_busy", Busy, 0);
    checkOutput("midreset_stepcount", StepCount, 0);
    Button = 1'b0;
    repeat (3) @(negedge CLK);
    Reset     = 1'b1;
    startRise = riseCount;
    repeat (40) @(negedge CLK);
    checkOutput("postreset_pulses", riseCount - startRise, 0);
    checkOutput("postreset_stepcount", StepCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
